// File: rtl/sha_multi_core_regs.sv
// Wishbone register file fronting NUM_CORES SHA-256 compression cores: one 256-byte window
// per core (control, message, state, status, cycle count) plus a global IRQ/info window.
module sha_multi_core_regs #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     wb_rst_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_we_i,
  input  logic                     wb_re_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic [NUM_CORES-1:0]     start_o,
  input  logic [NUM_CORES-1:0]     done_i,
  input  logic [NUM_CORES-1:0]     overflow_i,
  output logic [NUM_CORES*512-1:0] msg_o,
  output logic [NUM_CORES*256-1:0] state_in_o,
  input  logic [NUM_CORES*256-1:0] state_out_i,
  output logic                     irq_o
);

  localparam int unsigned WinW = ADDR_W - 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Word offsets (byte offset / 4) inside a core window.
  localparam logic [5:0] WCtrl     = 6'd0;
  localparam logic [5:0] WMsg0     = 6'd1;
  localparam logic [5:0] WMsgLast  = 6'd16;
  localparam logic [5:0] WSin0     = 6'd17;
  localparam logic [5:0] WSinLast  = 6'd24;
  localparam logic [5:0] WSout0    = 6'd25;
  localparam logic [5:0] WSoutLast = 6'd32;
  localparam logic [5:0] WStatus   = 6'd33;
  localparam logic [5:0] WCycles   = 6'd34;

  logic [WinW-1:0] win;
  logic [5:0]      word;
  logic            glb_sel;
  logic            pend_wr;
  logic            unused_addr_lsb;

  assign win             = wb_addr_i[ADDR_W-1:8];
  assign word            = wb_addr_i[7:2];
  assign glb_sel         = &win;
  assign pend_wr         = wb_we_i & glb_sel & (word == 6'd0);
  assign unused_addr_lsb = ^wb_addr_i[1:0];

  logic [NUM_CORES-1:0]       done_vec, busy_vec, irq_vec, core_sel;
  logic [NUM_CORES-1:0][31:0] core_rdat;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [1:0]        state_q, state_d;
    logic [15:0][31:0] msg_q;
    logic [7:0][31:0]  sin_q, sout_q;
    logic              ovf_q, done_q, err_q, irq_en_q;
    logic [CNT_W-1:0]  cyc_q;
    logic              sel, wr, busy, done_ev, ctrl_wr, go_wr, go_start;
    logic              data_wr, status_wr, done_clr;
    logic [31:0]       rdat;

    assign sel       = (win == WinW'(c));
    assign wr        = wb_we_i & sel;
    assign busy      = (state_q == StStart) | (state_q == StRun);
    assign done_ev   = done_i[c] & busy;
    assign ctrl_wr   = wr & (word == WCtrl);
    assign go_wr     = ctrl_wr & wb_dat_i[0];
    assign go_start  = go_wr & ~busy;
    assign data_wr   = wr & (word >= WMsg0) & (word <= WSinLast);
    assign status_wr = wr & (word == WStatus);
    assign done_clr  = (status_wr & wb_dat_i[2]) | (pend_wr & wb_dat_i[c]);

    always_comb begin
      state_d = state_q;
      case (state_q)
        StIdle, StDone: if (go_wr) state_d = StStart;
        StStart:        state_d = done_i[c] ? StDone : StRun;
        StRun:          if (done_i[c]) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        state_q  <= StIdle;
        msg_q    <= '0;
        sin_q    <= '0;
        sout_q   <= '0;
        ovf_q    <= 1'b0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        irq_en_q <= 1'b0;
        cyc_q    <= '0;
      end else begin
        state_q <= state_d;
        if (ctrl_wr) irq_en_q <= wb_dat_i[1];
        if (data_wr && !busy) begin
          if (word <= WMsgLast) msg_q[4'(word - WMsg0)] <= wb_dat_i;
          else                  sin_q[3'(word - WSin0)] <= wb_dat_i;
        end
        if (done_ev) begin
          sout_q <= state_out_i[c*256 +: 256];
          ovf_q  <= overflow_i[c];
        end
        // A completion arriving with a W1C keeps DONE set.
        if (go_start)      done_q <= 1'b0;
        else if (done_ev)  done_q <= 1'b1;
        else if (done_clr) done_q <= 1'b0;
        if (busy && (go_wr || data_wr))        err_q <= 1'b1;
        else if (status_wr && wb_dat_i[3])     err_q <= 1'b0;
        if (go_start) begin
          cyc_q <= '0;
        end else if (((state_q == StRun) || done_ev) && (cyc_q != '1)) begin
          cyc_q <= cyc_q + CNT_W'(1);
        end
      end
    end

    always_comb begin
      rdat = '0;
      if (word == WCtrl)           rdat = {30'd0, irq_en_q, busy};
      else if (word <= WMsgLast)   rdat = msg_q[4'(word - WMsg0)];
      else if (word <= WSinLast)   rdat = sin_q[3'(word - WSin0)];
      else if (word <= WSoutLast)  rdat = sout_q[3'(word - WSout0)];
      else if (word == WStatus)    rdat = {28'd0, err_q, done_q, busy, ovf_q};
      else if (word == WCycles)    rdat = 32'(cyc_q);
    end

    assign start_o[c]               = (state_q == StStart);
    assign msg_o[c*512 +: 512]      = msg_q;
    assign state_in_o[c*256 +: 256] = sin_q;
    assign done_vec[c]              = done_q;
    assign busy_vec[c]              = busy;
    assign irq_vec[c]               = done_q & irq_en_q;
    assign core_sel[c]              = sel;
    assign core_rdat[c]             = rdat;
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (glb_sel) begin
      case (word)
        6'd0:    rd_mux = 32'(done_vec);
        6'd1:    rd_mux = {16'h5A25, 8'd0, 8'(NUM_CORES)};
        6'd2:    rd_mux = 32'(busy_vec);
        default: rd_mux = '0;
      endcase
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (core_sel[c]) rd_mux = core_rdat[c];
      end
    end
  end

  logic        ack_q, irq_q;
  logic [31:0] dat_q;

  // A simultaneous read+write is serviced as a write and returns zero data.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= wb_we_i | wb_re_i;
      dat_q <= (wb_re_i & ~wb_we_i) ? rd_mux : '0;
      irq_q <= |irq_vec;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_sha_multi_core_regs.sv
// Bench for sha_multi_core_regs: a 32-bit-counter and a 4-bit-counter instance share stimulus
// and are checked every cycle against a behavioural model, plus directed literal checks.
module tb_sha_multi_core_regs;
  localparam int NC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              wb_rst_i;
  logic [11:0]       wb_addr_i;
  logic [31:0]       wb_dat_i;
  logic              wb_we_i, wb_re_i;
  logic [NC-1:0]     done_i, overflow_i;
  logic [NC*256-1:0] state_out_i;

  logic [31:0]       dat_a, dat_b;
  logic              ack_a, ack_b, irq_a, irq_b;
  logic [NC-1:0]     start_a, start_b;
  logic [NC*512-1:0] msg_a, msg_b;
  logic [NC*256-1:0] sin_a, sin_b;

  sha_multi_core_regs #(.NUM_CORES(NC), .ADDR_W(12), .CNT_W(32)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_re_i(wb_re_i), .wb_dat_o(dat_a), .wb_ack_o(ack_a),
    .start_o(start_a), .done_i(done_i), .overflow_i(overflow_i), .msg_o(msg_a),
    .state_in_o(sin_a), .state_out_i(state_out_i), .irq_o(irq_a)
  );

  sha_multi_core_regs #(.NUM_CORES(NC), .ADDR_W(12), .CNT_W(4)) dut4 (
    .clk(clk), .wb_rst_i(wb_rst_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_re_i(wb_re_i), .wb_dat_o(dat_b), .wb_ack_o(ack_b),
    .start_o(start_b), .done_i(done_i), .overflow_i(overflow_i), .msg_o(msg_b),
    .state_in_o(sin_b), .state_out_i(state_out_i), .irq_o(irq_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_w(input string nm, input logic [1023:0] act,
                                input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int k = 0; k < 32; k++) begin
        if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL %s word %0d: got %h want %h (t=%0t)", nm, k, act[k*32 +: 32],
                   exp[k*32 +: 32], $time);
          break;
        end
      end
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_msg  [NC][16];
  logic [31:0] m_sin  [NC][8];
  logic [31:0] m_sout [NC][8];
  bit          m_ovf[NC], m_busy[NC], m_instart[NC], m_done[NC], m_err[NC], m_ien[NC];
  int unsigned m_cyc[NC];
  bit          m_irq, m_ack;
  logic [31:0] m_dat32, m_dat4;

  function automatic logic [31:0] m_read(input logic [11:0] a, input int unsigned cmax);
    int w, o;
    logic [31:0] r;
    w = int'(a[11:8]);
    o = int'(a[7:2]);
    r = 32'd0;
    if (w == 15) begin
      if (o == 0)      for (int c = 0; c < NC; c++) r[c] = m_done[c];
      else if (o == 1) r = 32'h5A25_0000 + NC;
      else if (o == 2) for (int c = 0; c < NC; c++) r[c] = m_busy[c];
    end else if (w < NC) begin
      if (o == 0)                r = {30'd0, m_ien[w], m_busy[w]};
      else if (o <= 16)          r = m_msg[w][o-1];
      else if (o <= 24)          r = m_sin[w][o-17];
      else if (o <= 32)          r = m_sout[w][o-25];
      else if (o == 33)          r = {28'd0, m_err[w], m_done[w], m_busy[w], m_ovf[w]};
      else if (o == 34)          r = (m_cyc[w] > cmax) ? cmax : m_cyc[w];
    end
    return r;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 16; k++) m_msg[c][k] = 32'd0;
      for (int k = 0; k < 8; k++) begin
        m_sin[c][k]  = 32'd0;
        m_sout[c][k] = 32'd0;
      end
      m_ovf[c] = 0; m_busy[c] = 0; m_instart[c] = 0; m_done[c] = 0; m_err[c] = 0;
      m_ien[c] = 0; m_cyc[c] = 0;
    end
    m_irq = 0; m_ack = 0; m_dat32 = 32'd0; m_dat4 = 32'd0;
  endtask

  task automatic m_step();
    int w, o;
    bit we, re, busy0, start0, dev, wr;
    we = wb_we_i;
    re = wb_re_i;
    w  = int'(wb_addr_i[11:8]);
    o  = int'(wb_addr_i[7:2]);
    m_irq = 0;
    for (int c = 0; c < NC; c++) if (m_done[c] && m_ien[c]) m_irq = 1;
    m_ack   = we | re;
    m_dat32 = (re && !we) ? m_read(wb_addr_i, 32'hFFFF_FFFF) : 32'd0;
    m_dat4  = (re && !we) ? m_read(wb_addr_i, 32'd15) : 32'd0;
    for (int c = 0; c < NC; c++) begin
      busy0  = m_busy[c];
      start0 = m_instart[c];
      dev    = done_i[c] && busy0;
      wr     = we && (w == c);
      // Cycles count RUN cycles, plus the completing cycle.
      if (busy0 && (!start0 || dev) && m_cyc[c] != 32'hFFFF_FFFF) m_cyc[c]++;
      m_instart[c] = 0;
      if (dev) begin
        m_busy[c] = 0;
        m_done[c] = 1;
        m_ovf[c]  = overflow_i[c];
        for (int k = 0; k < 8; k++) m_sout[c][k] = state_out_i[c*256 + k*32 +: 32];
      end
      if (wr) begin
        if (o == 0) begin
          m_ien[c] = wb_dat_i[1];
          if (wb_dat_i[0]) begin
            if (busy0) m_err[c] = 1;
            else begin
              m_busy[c] = 1; m_instart[c] = 1; m_done[c] = 0; m_cyc[c] = 0;
            end
          end
        end else if (o <= 24) begin
          if (busy0)        m_err[c] = 1;
          else if (o <= 16) m_msg[c][o-1] = wb_dat_i;
          else              m_sin[c][o-17] = wb_dat_i;
        end else if (o == 33) begin
          if (wb_dat_i[2] && !dev) m_done[c] = 0;
          if (wb_dat_i[3])         m_err[c] = 0;
        end
      end
      if (we && w == 15 && o == 0 && wb_dat_i[c] && !dev) m_done[c] = 0;
    end
  endtask

  always @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) m_reset();
    else          m_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [NC-1:0]     exp_start;
  logic [NC*512-1:0] exp_msg;
  logic [NC*256-1:0] exp_sin;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        exp_start[c] = m_instart[c];
        for (int k = 0; k < 16; k++) exp_msg[c*512 + k*32 +: 32] = m_msg[c][k];
        for (int k = 0; k < 8; k++)  exp_sin[c*256 + k*32 +: 32] = m_sin[c][k];
      end
      chk("start_o", 32'(start_a), 32'(exp_start));
      chk("start_o_n4", 32'(start_b), 32'(exp_start));
      chk("irq_o", 32'(irq_a), 32'(m_irq));
      chk("irq_o_n4", 32'(irq_b), 32'(m_irq));
      chk("ack", 32'(ack_a), 32'(m_ack));
      chk("ack_n4", 32'(ack_b), 32'(m_ack));
      if (m_ack) begin
        chk("rdata", dat_a, m_dat32);
        chk("rdata_n4", dat_b, m_dat4);
      end
      chk_w("msg_o", 1024'(msg_a), 1024'(exp_msg));
      chk_w("msg_o_n4", 1024'(msg_b), 1024'(exp_msg));
      chk_w("state_in_o", 1024'(sin_a), 1024'(exp_sin));
      chk_w("state_in_o_n4", 1024'(sin_b), 1024'(exp_sin));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wb_addr_i = a; wb_dat_i = d; wb_we_i = 1'b1;
    tick();
    wb_we_i = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] e32,
                        input logic [31:0] e4);
    wb_addr_i = a; wb_re_i = 1'b1;
    tick();
    wb_re_i = 1'b0;
    chk({nm, "_ack"}, 32'(ack_a), 32'd1);
    chk(nm, dat_a, e32);
    chk({nm, "_n4"}, dat_b, e4);
  endtask

  logic [31:0] iv   [8];
  logic [31:0] habc [8];

  initial begin
    iv   = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
             32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    habc = '{32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
             32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};
    wb_rst_i = 1'b1; wb_we_i = 1'b0; wb_re_i = 1'b0; wb_addr_i = '0; wb_dat_i = '0;
    done_i = '0; overflow_i = '0;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < 8; k++) state_out_i[c*256 + k*32 +: 32] = habc[k];
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_dat", dat_a, 32'd0);
    chk("rst_irq", 32'(irq_a), 32'd0);
    chk("rst_start", 32'(start_a), 32'd0);
    wb_rst_i = 1'b0;
    tick();
    rd_chk("rst_status0", 12'h084, 32'd0, 32'd0);

    // Core 1: "abc" block with the SHA-256 IV.
    wr(12'h104, 32'h61626380);
    for (int k = 1; k < 15; k++) wr(12'h104 + 12'(4*k), 32'd0);
    wr(12'h140, 32'h18);
    for (int k = 0; k < 8; k++) wr(12'h144 + 12'(4*k), iv[k]);
    wr(12'h100, 32'h3);
    chk("go_pulse", 32'(start_a), 32'h2);
    tick();
    chk("go_pulse_once", 32'(start_a), 32'h0);
    repeat (63) tick();
    done_i[1] = 1'b1;
    tick();
    done_i = '0;
    rd_chk("sout0", 12'h164, 32'hBA7816BF, 32'hBA7816BF);
    rd_chk("sout7", 12'h180, 32'hF20015AD, 32'hF20015AD);
    rd_chk("status1", 12'h184, 32'h4, 32'h4);
    rd_chk("cycles1", 12'h188, 32'd64, 32'hF);
    chk("irq_set", 32'(irq_a), 32'd1);
    rd_chk("irq_pend", 12'hF00, 32'h2, 32'h2);
    rd_chk("msg0", 12'h104, 32'h61626380, 32'h61626380);

    // W1C, then W1C racing a fresh completion.
    wr(12'h184, 32'h4);
    chk("irq_hold", 32'(irq_a), 32'd1);
    tick();
    chk("irq_clr", 32'(irq_a), 32'd0);
    rd_chk("pend_clr", 12'hF00, 32'h0, 32'h0);
    wr(12'h100, 32'h3);
    repeat (2) tick();
    done_i[1] = 1'b1;
    wr(12'h184, 32'h4);
    done_i = '0;
    rd_chk("set_wins", 12'h184, 32'h4, 32'h4);

    // Core 0 write protection while running.
    wr(12'h000, 32'h1);
    repeat (2) tick();
    wr(12'h010, 32'hDEADBEEF);
    wr(12'h000, 32'h1);
    chk("no_restart", 32'(start_a), 32'd0);
    rd_chk("msg3_prot", 12'h010, 32'd0, 32'd0);
    rd_chk("status0_err", 12'h084, 32'hA, 32'hA);
    rd_chk("busy_mask", 12'hF08, 32'h1, 32'h1);
    rd_chk("ctrl0_busy", 12'h000, 32'h1, 32'h1);

    // Decode corners.
    rd_chk("info", 12'hF04, 32'h5A250002, 32'h5A250002);
    rd_chk("unmapped", 12'h300, 32'd0, 32'd0);
    wr(12'h164, 32'h12345678);
    rd_chk("sout_ro", 12'h164, 32'hBA7816BF, 32'hBA7816BF);
    wb_addr_i = 12'hF04; wb_dat_i = 32'd0; wb_we_i = 1'b1; wb_re_i = 1'b1;
    tick();
    wb_we_i = 1'b0; wb_re_i = 1'b0;
    chk("we_re_ack", 32'(ack_a), 32'd1);
    chk("we_re_dat", dat_a, 32'd0);

    // Reset while core 0 runs; a stale done must be ignored.
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    tick();
    done_i[0] = 1'b1;
    tick();
    done_i = '0;
    rd_chk("rr_status", 12'h084, 32'd0, 32'd0);
    rd_chk("rr_sout", 12'h064, 32'd0, 32'd0);
    rd_chk("rr_busy", 12'hF08, 32'd0, 32'd0);
    rd_chk("rr_msg", 12'h104, 32'd0, 32'd0);
    chk("rr_irq", 32'(irq_a), 32'd0);

    // Counter saturation in the 4-bit instance.
    wr(12'h000, 32'h1);
    tick();
    repeat (20) tick();
    rd_chk("sat_cycles", 12'h088, 32'd20, 32'hF);
    done_i[0] = 1'b1;
    tick();
    done_i = '0;

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int unsigned p, r;
      logic [3:0] w;
      logic [5:0] o;
      r = $urandom_range(0, 3);
      w = (r == 3) ? 4'hF : 4'(r);
      o = (w == 4'hF) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 37));
      wb_addr_i = {w, o, 2'($urandom)};
      wb_dat_i  = $urandom;
      p = $urandom_range(0, 99);
      wb_we_i = (p >= 35 && p < 70) || p >= 95;
      wb_re_i = (p >= 70);
      for (int c = 0; c < NC; c++) begin
        done_i[c]     = ($urandom_range(0, 15) == 0);
        overflow_i[c] = 1'($urandom);
      end
      for (int k = 0; k < NC*8; k++) state_out_i[k*32 +: 32] = $urandom;
      wb_rst_i = ($urandom_range(0, 999) == 0);
      tick();
    end
    wb_we_i = 1'b0; wb_re_i = 1'b0; done_i = '0; wb_rst_i = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_multi_core_regs.md
Name: sha_multi_core_regs

Overview:
- Parametrised Wishbone-side register file for NUM_CORES SHA-256 compression cores.
- Each core gets a 256-byte register window containing control, message, input state, latched output state, status and a latency counter.
- Each core has its own run FSM. Message and input-state registers are write-protected while the core is busy; illegal writes set a sticky error flag.
- A global window provides an interrupt pending/W1C register and a busy mask; irq_o goes to the CPU interrupt controller.

Parameters:
NUM_CORES, 2, number of SHA-256 cores served (1..15)
ADDR_W, 12, byte-address width; bits [ADDR_W-1:8] select the window, bits [7:0] the offset
CNT_W, 32, width of per-core cycle counter (saturating)

Ports:
clk  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_addr_i  in  ADDR_W  byte address (word aligned; bits [1:0] ignored)
wb_dat_i  in  32  write data
wb_we_i  in  1  write strobe, one cycle per access
wb_re_i  in  1  read strobe, one cycle per access
wb_dat_o  out  32  registered read data, valid with wb_ack_o
wb_ack_o  out  1  one-cycle ack, one cycle after wb_we_i or wb_re_i
start_o  out  NUM_CORES  one-cycle start pulse per core
done_i  in  NUM_CORES  one-cycle done pulse per core
overflow_i  in  NUM_CORES  core overflow flag, sampled on done
msg_o  out  NUM_CORES*512  message block; core c at [c*512+:512], word k at [c*512+k*32+:32]
state_in_o  out  NUM_CORES*256  input hash state, same packing
state_out_i  in  NUM_CORES*256  core output hash state, same packing
irq_o  out  1  level interrupt

Behaviour:
- Reset: all registers, counters and irq_o are 0; all FSMs go to IDLE. start_o=0, wb_ack_o=0, wb_dat_o=0.
- Window decode:
  - Window w = addr[ADDR_W-1:8].
  - w < NUM_CORES selects core w.
  - w = all-ones selects the global window.
  - Any other window: reads return 0, writes are ignored, ack is still given.
- Core window offsets:
  - 0x00 CTRL: bit0 GO (W; reads 1 while busy), bit1 IRQ_EN (R/W).
  - 0x04-0x40 MSG[0..15], R/W.
  - 0x44-0x60 STATE_IN[0..7], R/W.
  - 0x64-0x80 STATE_OUT[0..7], RO, latched on done.
  - 0x84 STATUS: bit0 OVF (RO, latched on done), bit1 BUSY (RO), bit2 DONE (sticky, W1C), bit3 WR_ERR (sticky, W1C).
  - 0x88 CYCLES: RO.
  - Unmapped offsets read 0; writes to them are ignored.
- Global window offsets:
  - 0x00 IRQ_PEND: bit c = DONE[c]; W1C, with the same effect as clearing STATUS.DONE.
  - 0x04 INFO: {16'h5A25, 8'd0, NUM_CORES[7:0]}.
  - 0x08 BUSY_MASK.
- Per-core FSM, states IDLE, START, RUN, DONE:
  - IDLE/DONE: a CTRL write with bit0=1 goes to START. Entering START clears DONE and CYCLES.
  - START: lasts exactly one cycle, with start_o[c]=1. Then goes to RUN.
  - RUN: CYCLES increments by 1 per cycle, saturating at all-ones.
  - done_i[c] in START or RUN goes to DONE in the next cycle. Also on that edge: latch STATE_OUT and OVF, set DONE, and CYCLES takes its final increment.
  - done_i in IDLE/DONE is ignored; nothing is latched.
- BUSY = state in {START, RUN}.
- Protection while BUSY:
  - Writes to MSG or STATE_IN are dropped and set WR_ERR.
  - A CTRL write with GO=1 is ignored (no restart) and sets WR_ERR; IRQ_EN is still updated.
- Simultaneous events:
  - done_i and a W1C of DONE in the same cycle: the set wins.
  - done_i and a GO write in the same cycle while in RUN: done is taken and GO is flagged as WR_ERR.
- Interrupt: irq_o = OR over c of (DONE[c] & IRQ_EN[c]), registered, so it updates one cycle after the cause.
- Bus timing:
  - A write takes effect on the strobe edge.
  - A read captures the register value at the strobe edge and presents it in wb_dat_o with wb_ack_o on the following cycle.
  - wb_we_i and wb_re_i asserted together: treated as a write; ack is given; wb_dat_o = 0.
- Outputs msg_o and state_in_o are direct register outputs, with no latency beyond the write edge.
- Reset mid-operation: the FSM returns to IDLE immediately; a later done_i from the core is ignored.

Test Plan:
- Core 1 (NUM_CORES=2): write MSG[0..15]=0x61626380,0,...,0x18 and STATE_IN to the SHA-256 IV, then CTRL=0x3 -> one start_o[1] pulse. Drive done_i[1] with state_out=BA7816BF... after 64 cycles -> STATE_OUT reads BA7816BF..., STATUS=0x4, CYCLES=64, irq_o=1, IRQ_PEND=0x2.
- Write 0x4 to STATUS of core 1 -> DONE=0, IRQ_PEND=0, irq_o=0 the next cycle. Repeat with the W1C in the same cycle as a new done_i -> DONE stays 1.
- While core 0 is in RUN, write MSG[3]=0xDEADBEEF and CTRL=0x1 -> MSG[3] unchanged, no second start_o, WR_ERR=1, BUSY_MASK=0x1.
- Read address 0x0F04 -> 0x5A250002 with ack one cycle later. Read 0x0300 -> 0 with ack. Write to STATE_OUT -> value unchanged.
- Assert wb_rst_i during RUN, release it, then pulse done_i[0] -> state IDLE, STATUS=0, irq_o=0, all MSG=0.
- Force the counter to CNT_W=4 and hold RUN for 20 cycles -> CYCLES=0xF (saturated).
